// File: rtl/comb_sweep_pkg.sv
// Shared definitions for the combinational-unit sweep controller: state
// encoding, default sweep parameters and the error counter ceiling.
package comb_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FIN    = 2'd3
  } sweep_state_t;

  localparam int unsigned SETTLE_DEFAULT   = 2;
  localparam logic [7:0]  EXPECTED_DEFAULT = 8'hEA;
  localparam logic [3:0]  ERR_MAX          = 4'd8;

endpackage

// File: rtl/comb_sweep_ctrl.sv
// Walks a 3-input combinational unit through all eight input codes, captures
// its response into a truth table and counts mismatches against a golden one.
module comb_sweep_ctrl
  import comb_sweep_pkg::*;
#(
  parameter int unsigned SETTLE   = SETTLE_DEFAULT,
  parameter logic [7:0]  EXPECTED = EXPECTED_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       f,
  output logic [2:0] x,
  output logic       busy,
  output logic       done,
  output logic [7:0] tt,
  output logic [3:0] err_cnt,
  output logic       match
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  sweep_state_t state;
  logic [3:0]   settle_cnt;

  function automatic logic [3:0] err_inc(input logic [3:0] cnt);
    return (cnt >= ERR_MAX) ? ERR_MAX : cnt + 4'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      x          <= 3'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tt         <= 8'h00;
      err_cnt    <= 4'd0;
      match      <= 1'b0;
      settle_cnt <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // abort beats a simultaneous start request
          if (start && !abort) begin
            state      <= ST_SETTLE;
            busy       <= 1'b1;
            x          <= 3'd0;
            tt         <= 8'h00;
            err_cnt    <= 4'd0;
            match      <= 1'b0;
            settle_cnt <= SETTLE_LD;
          end
        end

        ST_SETTLE: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            x     <= 3'd0;
            match <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
            if (settle_cnt <= 4'd1) state <= ST_SAMPLE;
          end
        end

        ST_SAMPLE: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            x     <= 3'd0;
            match <= 1'b0;
          end else begin
            tt[x] <= f;
            if (f != EXPECTED[x]) err_cnt <= err_inc(err_cnt);
            // last code holds x at 7 through FIN rather than wrapping
            if (x == 3'd7) begin
              state <= ST_FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              x          <= x + 3'd1;
              settle_cnt <= SETTLE_LD;
              state      <= ST_SETTLE;
            end
          end
        end

        ST_FIN: begin
          state <= ST_IDLE;
          x     <= 3'd0;
          match <= (err_cnt == 4'd0);
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          x     <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// Bench for comb_sweep_ctrl: table vectors, corner-case sequences and random
// sweeps against a behavioural model of the sweep timing and results.
module tb_comb_sweep_ctrl;
  localparam int S = 2;
  localparam int L = 8 * (S + 1);
  localparam logic [7:0] GOLD = 8'hEA;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] func_tt = GOLD;

  logic       f1, busy1, done1, match1;
  logic [2:0] x1;
  logic [7:0] tt1;
  logic [3:0] err1;
  logic       f2, busy2, done2, match2;
  logic [2:0] x2;
  logic [7:0] tt2;
  logic [3:0] err2;

  int n_chk = 0;
  int n_fail = 0;

  assign f1 = func_tt[x1];
  assign f2 = func_tt[x2];

  always #5 clk = ~clk;

  comb_sweep_ctrl #(.SETTLE(S), .EXPECTED(GOLD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .f(f1),
    .x(x1), .busy(busy1), .done(done1), .tt(tt1), .err_cnt(err1), .match(match1)
  );

  comb_sweep_ctrl #(.SETTLE(1), .EXPECTED(GOLD)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .f(f2),
    .x(x2), .busy(busy2), .done(done2), .tt(tt2), .err_cnt(err2), .match(match2)
  );

  typedef struct {
    logic [7:0] fn;
    logic [7:0] tt;
    logic [3:0] err;
    logic       match;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result of a sweep: code k is captured at edge (k+1)*(S+1); an abort seen
  // at edge abort_at+1 keeps only codes captured strictly before that edge.
  function automatic void model(input logic [7:0] fn, input int abort_at,
                                output logic [7:0] e_tt, output logic [3:0] e_err,
                                output logic e_match);
    int nsamp;
    logic [7:0] mask;
    nsamp = 0;
    for (int k = 0; k < 8; k++)
      if (abort_at < 0 || (k + 1) * (S + 1) <= abort_at) nsamp++;
    mask = 8'((9'd1 << nsamp) - 9'd1);
    e_tt = fn & mask;
    e_err = 4'($countones((fn ^ GOLD) & mask));
    e_match = (abort_at < 0) && (e_err == 4'd0);
  endfunction

  task automatic sweep(input logic [7:0] fn, input int abort_at, input bit extra,
                       input logic [7:0] e_tt, input logic [3:0] e_err, input logic e_match);
    func_tt = fn;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c <= L; c++) begin
      chk("x", 32'(x1), (c < L) ? 32'(c / (S + 1)) : 32'd7);
      chk("busy", 32'(busy1), 32'(c < L));
      chk("done", 32'(done1), 32'(c == L));
      if (c == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        break;
      end
      start = extra && (c == 5 || c == 10);
      tick();
      start = 1'b0;
    end
    chk("end_x", 32'(x1), 32'd0);
    chk("end_busy", 32'(busy1), 32'd0);
    chk("end_done", 32'(done1), 32'd0);
    chk("tt", 32'(tt1), 32'(e_tt));
    chk("err_cnt", 32'(err1), 32'(e_err));
    chk("match", 32'(match1), 32'(e_match));
    tick();
    tick();
    chk("tt_hold", 32'(tt1), 32'(e_tt));
    chk("err_hold", 32'(err1), 32'(e_err));
    chk("done_quiet", 32'(done1), 32'd0);
  endtask

  initial begin
    logic [7:0] m_tt;
    logic [3:0] m_err;
    logic       m_match;
    logic [7:0] rfn;
    int         ab;

    vecs[0] = '{8'hEA, 8'hEA, 4'd0, 1'b1};
    vecs[1] = '{8'h00, 8'h00, 4'd5, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 4'd3, 1'b0};
    vecs[3] = '{8'h15, 8'h15, 4'd8, 1'b0};
    vecs[4] = '{8'hEB, 8'hEB, 4'd1, 1'b0};
    vecs[5] = '{8'h6A, 8'h6A, 4'd1, 1'b0};

    tick();
    tick();
    chk("rst_x", 32'(x1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_tt", 32'(tt1), 32'd0);
    chk("rst_err", 32'(err1), 32'd0);
    chk("rst_match", 32'(match1), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++)
      sweep(vecs[i].fn, -1, 1'b0, vecs[i].tt, vecs[i].err, vecs[i].match);

    // abort during the first settle cycle of code 3
    sweep(GOLD, 3 * (S + 1), 1'b0, 8'h02, 4'd0, 1'b0);
    // abort in the final sample cycle beats FIN
    sweep(8'h00, L - 1, 1'b0, 8'h00, 4'd4, 1'b0);
    // stray start pulses while busy
    sweep(GOLD, -1, 1'b1, GOLD, 4'd0, 1'b1);

    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_wins_busy", 32'(busy1), 32'd0);
    chk("abort_wins_tt", 32'(tt1), 32'(GOLD));

    // asynchronous reset mid-sweep at code 5
    func_tt = GOLD;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5 * (S + 1)) tick();
    chk("pre_rst_x", 32'(x1), 32'd5);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_x", 32'(x1), 32'd0);
    chk("arst_busy", 32'(busy1), 32'd0);
    chk("arst_tt", 32'(tt1), 32'd0);
    chk("arst_err", 32'(err1), 32'd0);
    chk("arst_match", 32'(match1), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    sweep(GOLD, -1, 1'b0, GOLD, 4'd0, 1'b1);

    // start held high: FIN ignores it, IDLE re-accepts it
    start = 1'b1;
    tick();
    repeat (L) tick();
    chk("hold_done", 32'(done1), 32'd1);
    tick();
    chk("hold_idle_busy", 32'(busy1), 32'd0);
    tick();
    chk("hold_restart_busy", 32'(busy1), 32'd1);
    chk("hold_restart_x", 32'(x1), 32'd0);
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("hold_abort_busy", 32'(busy1), 32'd0);

    for (int it = 0; it < 20; it++) begin
      rfn = 8'($urandom);
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, L - 1)) : -1;
      model(rfn, ab, m_tt, m_err, m_match);
      sweep(rfn, ab, 1'($urandom_range(0, 1)), m_tt, m_err, m_match);
    end

    // SETTLE=1 instance: x advances every two cycles, done at 16
    repeat (30) tick();
    func_tt = GOLD;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      chk("s1_x", 32'(x2), (c < 16) ? 32'(c / 2) : 32'd7);
      chk("s1_done", 32'(done2), 32'(c == 16));
      tick();
    end
    chk("s1_tt", 32'(tt2), 32'(GOLD));
    chk("s1_err", 32'(err2), 32'd0);
    chk("s1_match", 32'(match2), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
